// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed array with zero-latency reads behind a posted write buffer.
// Define DMEM_WBUF_EN to build the write buffer; otherwise writes go straight to the array.
module dmem_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WBUF_D = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     DM_en,
   input  logic                     DM_write,
   input  logic [31:0]              DM_address,
   input  logic [31:0]              DM_in,
   output logic [31:0]              DM_out,
   output logic [$clog2(WBUF_D):0]  wbuf_count,
   output logic                     wbuf_empty
);

   localparam int unsigned PTR_W = $clog2(WBUF_D);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] idx;
   logic              rd_req;
   logic              wr_req;
   logic [31:0]       rd_data;
   logic              unused_addr;

   logic [31:0] mem [DEPTH];

   // Byte-offset bits and bits above the array index are ignored (aliasing wrap).
   assign idx         = DM_address[ADDR_W+1:2];
   assign unused_addr = ^{DM_address[31:ADDR_W+2], DM_address[1:0]};
   assign rd_req      = DM_en & ~DM_write;
   assign wr_req      = DM_en & DM_write;

`ifdef DMEM_WBUF_EN

   logic [ADDR_W-1:0] wb_idx_q  [WBUF_D];
   logic [31:0]       wb_data_q [WBUF_D];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              push;
   logic              pop;
   logic              fwd_hit;
   logic [31:0]       fwd_data;
   logic [PTR_W-1:0]  pos;

   assign push = wr_req;
   // Drain uses every non-read cycle, including write cycles.
   assign pop  = (count_q != '0) && !rd_req;

   // Walk entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      pos      = '0;
      for (int unsigned i = 0; i < WBUF_D; i++) begin
         pos = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (wb_idx_q[pos] == idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data_q[pos];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry payloads need no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         wb_idx_q[tail_q]  <= idx;
         wb_data_q[tail_q] <= DM_in;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         mem[wb_idx_q[head_q]] <= wb_data_q[head_q];
      end
   end

   assign rd_data    = fwd_hit ? fwd_data : mem[idx];
   assign wbuf_count = count_q;
   assign wbuf_empty = (count_q == '0);

`else

   always_ff @(posedge clk) begin
      if (wr_req && !rst) begin
         mem[idx] <= DM_in;
      end
   end

   assign rd_data    = mem[idx];
   assign wbuf_count = '0;
   assign wbuf_empty = 1'b1;

`endif

   always_comb begin
      DM_out = '0;
      if (!rst && rd_req) begin
         DM_out = rd_data;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WBUF_D = 4;
   localparam int unsigned NWORDS = 32;

   logic                    clk;
   logic                    rst;
   logic                    DM_en;
   logic                    DM_write;
   logic [31:0]             DM_address;
   logic [31:0]             DM_in;
   logic [31:0]             DM_out;
   logic [$clog2(WBUF_D):0] wbuf_count;
   logic                    wbuf_empty;

   dmem_responder #(
      .ADDR_W (ADDR_W),
      .WBUF_D (WBUF_D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .DM_en      (DM_en),
      .DM_write   (DM_write),
      .DM_address (DM_address),
      .DM_in      (DM_in),
      .DM_out     (DM_out),
      .wbuf_count (wbuf_count),
      .wbuf_empty (wbuf_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned idx;
      logic [31:0] data;
   } ent_t;

   ent_t        pend[$];
   logic [31:0] shadow [2 ** ADDR_W];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic int unsigned word_of(input logic [31:0] addr);
      return (addr / 4) % (2 ** ADDR_W);
   endfunction

   // Model result of a read: youngest pending write to the word, else stored value.
   function automatic logic [31:0] model_read(input int unsigned w);
      logic [31:0] v;
      v = shadow[w];
      foreach (pend[i]) if (pend[i].idx == w) v = pend[i].data;
      return v;
   endfunction

   task automatic do_cycle(input logic en, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input string tag);
      logic [31:0] exp_out;
      int unsigned w;
      @(posedge clk);
      #1;
      DM_en      = en;
      DM_write   = wr;
      DM_address = addr;
      DM_in      = data;
      w          = word_of(addr);
      @(negedge clk);
      exp_out = (en && !wr) ? model_read(w) : 32'h0;
      check({tag, ".out"}, DM_out, exp_out);
`ifdef DMEM_WBUF_EN
      check({tag, ".count"}, 32'(wbuf_count), pend.size());
      check({tag, ".empty"}, 32'(wbuf_empty), 32'(pend.size() == 0));
      // Edge ending this cycle: drain oldest unless reading, then post the write.
      if (pend.size() > 0 && !(en && !wr)) begin
         shadow[pend[0].idx] = pend[0].data;
         void'(pend.pop_front());
      end
      if (en && wr) pend.push_back('{idx: w, data: data});
`else
      check({tag, ".count"}, 32'(wbuf_count), 32'h0);
      check({tag, ".empty"}, 32'(wbuf_empty), 32'h1);
      if (en && wr) shadow[w] = data;
`endif
   endtask

   // Asynchronous reset raised mid-cycle during a read request.
   task automatic reset_mid(input logic [31:0] addr, input string tag);
      @(posedge clk);
      #1;
      DM_en      = 1'b1;
      DM_write   = 1'b0;
      DM_address = addr;
      #2;
      rst = 1'b1;
      #1;
      check({tag, ".count"}, 32'(wbuf_count), 32'h0);
      check({tag, ".empty"}, 32'(wbuf_empty), 32'h1);
      check({tag, ".out"}, DM_out, 32'h0);
      pend.delete();
      @(posedge clk);
      #3;
      rst   = 1'b0;
      DM_en = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      rst        = 1'b1;
      DM_en      = 1'b0;
      DM_write   = 1'b0;
      DM_address = '0;
      DM_in      = '0;
      #1;
      check("rst.out", DM_out, 32'h0);
      check("rst.count", 32'(wbuf_count), 32'h0);
      check("rst.empty", 32'(wbuf_empty), 32'h1);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;

      // Give every word used below a known value.
      for (int i = 0; i < NWORDS; i++) do_cycle(1'b1, 1'b1, 32'(i * 4), $urandom, "init");
      do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "init_idle");

      // Forwarding then array read.
      do_cycle(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
      do_cycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, "fwd10");
      check("fwd10.lit", DM_out, 32'hDEAD_BEEF);
      do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
      do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
      do_cycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, "arr10");
      check("arr10.lit", DM_out, 32'hDEAD_BEEF);

      // Same-index writes: youngest wins.
      for (int i = 1; i <= 3; i++) do_cycle(1'b1, 1'b1, 32'h20, 32'(i), "wr20");
      do_cycle(1'b1, 1'b0, 32'h20, 32'h0, "rd20");
      check("rd20.lit", DM_out, 32'h3);
      do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
      do_cycle(1'b1, 1'b0, 32'h20, 32'h0, "rd20b");
      check("rd20b.lit", DM_out, 32'h3);

      // Writes held off by a run of reads, then read back after draining.
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, 32'(64 + i * 4), $urandom, "fill");
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 32'(64 + i * 4), 32'h0, "fill_rd");
      repeat (WBUF_D + 1) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 32'(64 + i * 4), 32'h0, "fill_chk");

      // Aliasing of high and low address bits.
      do_cycle(1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, "alias_wr");
      do_cycle(1'b1, 1'b0, 32'h0000_0004, 32'h0, "alias4");
      check("alias4.lit", DM_out, 32'hA5A5_A5A5);
      do_cycle(1'b1, 1'b0, 32'h0000_0006, 32'h0, "alias6");
      check("alias6.lit", DM_out, 32'hA5A5_A5A5);

      // Reset with writes still posted: undrained entries are lost.
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 32'(16 + i * 4), $urandom, "pre_rst");
      reset_mid(32'h14, "rst_mid");
      for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'(16 + i * 4), 32'h0, "post_rst");

      // Random traffic over a small word set with random alias and byte bits.
      for (int n = 0; n < 600; n++) begin
         a = ($urandom & ~32'h0000_0FFC) | (32'($urandom_range(NWORDS - 1)) << 2);
         do_cycle(($urandom_range(3) != 0), $urandom_range(1) == 1, a, $urandom, "rand");
         if (n == 300) reset_mid(a, "rand_rst");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
